bist_misr_checker: RTL and testbench
====================================

# bist_misr_checker

Output-response analyser that sits directly downstream of the BIST controller. It consumes the controller's `OUT`, `RUNNING`, `FINISH` and `BIST_END` strobes and compacts circuit-under-test (CUT) response words into a multiple-input signature register (MISR) while `OUT` is high. At `FINISH` it compares the signature and vector count against golden values, then latches PASS/FAIL until the controller leaves its end state.

## Interface
- `W`, 8, MISR and CUT data width (≥ 2)
- `POLY`, 8'h1D, Galois feedback taps (W bits)
- `INIT`, 8'h00, MISR start value
- `GOLDEN`, 8'h00, expected final signature
- `EXP_VECTORS`, 144, expected number of compacted words (9 × 16 from the controller); must fit in 10 bits

Ports:
- `CLK`  in  1  clock; all logic on the rising edge
- `RESET`  in  1  synchronous, active-high
- `OUT`  in  1  compaction enable; one CUT word is valid per cycle while high
- `RUNNING`  in  1  controller counting; informational only, no control effect
- `FINISH`  in  1  one-cycle end-of-test strobe
- `BIST_END`  in  1  controller end-state level
- `CUT_DATA`  in  W  CUT response word
- `SIGNATURE`  out  W  current MISR value
- `VEC_COUNT`  out  10  number of words compacted this run
- `BUSY`  out  1  high while in COMPACT
- `RESULT_VALID`  out  1  PASS/FAIL are meaningful
- `PASS`  out  1  signature and count matched
- `FAIL`  out  1  mismatch

## Operation
- MISR step: `next = {sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0) ^ CUT_DATA`.
- FSM states: IDLE, COMPACT, COMPARE, DONE (2-bit encoding).
- **IDLE**
  - `SIGNATURE` holds `INIT`.
  - `OUT`=1: `SIGNATURE <= step(INIT)`, `VEC_COUNT <= 1`, go to COMPACT.
  - `FINISH`=1 with `OUT`=0: go to COMPARE with `VEC_COUNT`=0.
- **COMPACT**
  - `OUT`=1: step the MISR and increment `VEC_COUNT`. The count saturates at 1023.
  - `OUT`=0: hold both.
  - `FINISH`=1: go to COMPARE. If `OUT`=1 in the same cycle, that word is compacted first.
- **COMPARE** (exactly one cycle)
  - `PASS <= (SIGNATURE==GOLDEN && VEC_COUNT==EXP_VECTORS)`; `FAIL <= !that`.
  - `RESULT_VALID <= 1`; go to DONE.
  - `OUT` and `FINISH` are ignored.
- **DONE**
  - Hold `SIGNATURE`, `VEC_COUNT` and the result.
  - `OUT` and `FINISH` are ignored.
  - `BIST_END`=0: go to IDLE, clearing `RESULT_VALID`, `PASS` and `FAIL`, with `SIGNATURE <= INIT` and `VEC_COUNT <= 0`. This covers the controller's S1 cycle before a restart.
- `PASS` and `FAIL` are never high simultaneously. Both are 0 whenever `RESULT_VALID`=0.
- An unreachable state encoding returns to IDLE on the next edge.

## Timing
- Reset values: state IDLE, `SIGNATURE`=`INIT`, `VEC_COUNT`=0, `BUSY`=0, `RESULT_VALID`=0, `PASS`=0, `FAIL`=0.
- `RESET` overrides every other input in the same edge, including mid-COMPACT and in DONE.
- A word sampled with `OUT`=1 at edge k appears in `SIGNATURE` and `VEC_COUNT` after edge k.
- `FINISH` sampled at edge k: COMPARE during cycle k..k+1. `RESULT_VALID`/`PASS`/`FAIL` are visible after edge k+1, so the latency is 2 edges.
- `BIST_END` low sampled at edge j in DONE: all outputs are at reset values after edge j.
- A new `OUT`=1 at edge j+1 starts compaction from `INIT`.
- `BUSY` is registered state decode and is high the cycle after the first `OUT` sample.

## Test plan
- **Reset:** `RESET`=1 for 2 cycles with `OUT`=1 and `CUT_DATA`=8'hFF → `SIGNATURE`=00, `VEC_COUNT`=0, all flags 0.
- **Short run, pass:** `EXP_VECTORS`=3, `GOLDEN`=8'h19. Drive `OUT`=1 for 3 cycles with data 01, 80, 00 → `SIGNATURE` goes 01, 82, 19. Then `FINISH` → `PASS`=1, `FAIL`=0, `RESULT_VALID`=1 two edges later.
- **Same run, count mismatch:** as above but one extra word 00 (`SIGNATURE`=32, `VEC_COUNT`=4) → `FAIL`=1.
- **Full controller run:** connect the BIST controller (N=9, M=16) with `GOLDEN` from the reference model → `VEC_COUNT`=144, `PASS`=1. Drop `BIST_END` → all flags clear. A second `START` repeats the run and reaches an identical `SIGNATURE`.
- **Simultaneous `OUT` and `FINISH`:** the last word is compacted, then compared. Separately, `FINISH` from IDLE with no words → `FAIL`=1 with `VEC_COUNT`=0.
- **Mid-run reset:** `RESET` asserted after 50 words → next cycle IDLE and `SIGNATURE`=`INIT`. No result is produced for the aborted run.

Source files
------------

// File: rtl/bist_misr_checker.sv
// bist_misr_checker: compacts CUT response words into a Galois MISR while OUT is high, then grades the run at FINISH.
// Latency: a word sampled at edge k is in SIGNATURE/VEC_COUNT after edge k; PASS/FAIL/RESULT_VALID follow FINISH by 2 edges.
// Backpressure: none; one word is taken every cycle OUT is high, and the verdict is held until BIST_END drops.
module bist_misr_checker #(
  parameter int           W           = 8,
  parameter logic [W-1:0] POLY        = 8'h1D,
  parameter logic [W-1:0] INIT        = 8'h00,
  parameter logic [W-1:0] GOLDEN      = 8'h00,
  parameter int           EXP_VECTORS = 144
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         OUT,
  input  logic         RUNNING,
  input  logic         FINISH,
  input  logic         BIST_END,
  input  logic [W-1:0] CUT_DATA,
  output logic [W-1:0] SIGNATURE,
  output logic [9:0]   VEC_COUNT,
  output logic         BUSY,
  output logic         RESULT_VALID,
  output logic         PASS,
  output logic         FAIL
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPACT = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic [9:0] EXP_CNT = 10'(EXP_VECTORS);

  state_t       state_q;
  logic [W-1:0] sig_q;
  logic [9:0]   cnt_q;
  logic         busy_q;
  logic         valid_q;
  logic         pass_q;
  logic         fail_q;

  logic [W-1:0] sig_step_d;
  logic [W-1:0] init_step_d;
  logic [9:0]   cnt_inc_d;
  logic         match_d;

  // RUNNING is carried for visibility only; it never steers the checker.
  logic         unused_running;
  assign unused_running = RUNNING;

  // One Galois MISR shift: feedback taps applied when the MSB falls out, then the CUT word folded in.
  function automatic logic [W-1:0] misr_step(input logic [W-1:0] sig, input logic [W-1:0] data);
    return {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : {W{1'b0}}) ^ data;
  endfunction

  // Candidate next values: MISR step from the live signature or from INIT, saturating count, and the verdict.
  always_comb begin
    sig_step_d  = misr_step(sig_q, CUT_DATA);
    init_step_d = misr_step(INIT, CUT_DATA);
    cnt_inc_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 10'd1;
    match_d     = (sig_q == GOLDEN) && (cnt_q == EXP_CNT);
  end

  // Control FSM with all outputs registered; RESET wins over every other input.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      sig_q   <= INIT;
      cnt_q   <= 10'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sig_q   <= INIT;
          cnt_q   <= 10'd0;
          valid_q <= 1'b0;
          pass_q  <= 1'b0;
          fail_q  <= 1'b0;
          if (OUT) begin
            // First word starts from INIT; a coincident FINISH grades this one-word run
            // rather than being dropped and leaving the checker waiting forever.
            sig_q <= init_step_d;
            cnt_q <= 10'd1;
            if (FINISH) begin
              state_q <= S_COMPARE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_COMPACT;
              busy_q  <= 1'b1;
            end
          end else if (FINISH) begin
            // Empty run: grade a zero count, which cannot match a sane expectation.
            state_q <= S_COMPARE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        S_COMPACT: begin
          if (OUT) begin
            sig_q <= sig_step_d;
            cnt_q <= cnt_inc_d;
          end
          // The word sampled alongside FINISH is already folded in above before grading.
          if (FINISH) begin
            state_q <= S_COMPARE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_COMPACT;
            busy_q  <= 1'b1;
          end
        end

        S_COMPARE: begin
          valid_q <= 1'b1;
          pass_q  <= match_d;
          fail_q  <= !match_d;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end

        S_DONE: begin
          busy_q <= 1'b0;
          // Leaving the controller end state (its S1 cycle) re-arms the checker for a fresh run.
          if (!BIST_END) begin
            state_q <= S_IDLE;
            sig_q   <= INIT;
            cnt_q   <= 10'd0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          sig_q   <= INIT;
          cnt_q   <= 10'd0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          pass_q  <= 1'b0;
          fail_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SIGNATURE    = sig_q;
  assign VEC_COUNT    = cnt_q;
  assign BUSY         = busy_q;
  assign RESULT_VALID = valid_q;
  assign PASS         = pass_q;
  assign FAIL         = fail_q;

endmodule

// File: tb/tb_bist_misr_checker.sv
// Bench for bist_misr_checker: short hand-computed runs on a 3-word instance, full 9x16 runs on a 144-word instance.
// Expected outputs are queued when each cycle's stimulus is driven and popped one edge later.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_bist_misr_checker;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] d);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ d;
  endfunction

  // Stand-in CUT response for controller word i.
  function automatic logic [7:0] word(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  function automatic logic [7:0] golden_full();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 144; i++) s = misr(s, word(i));
    return s;
  endfunction

  localparam logic [7:0] GOLD_B = golden_full();

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET, OUT, RUNNING, FINISH, BIST_END;
  logic [7:0] CUT_DATA;

  logic [7:0] a_sig, b_sig;
  logic [9:0] a_cnt, b_cnt;
  logic       a_busy, a_rv, a_pass, a_fail;
  logic       b_busy, b_rv, b_pass, b_fail;

  bist_misr_checker #(.W(8), .POLY(8'h1D), .INIT(8'h00), .GOLDEN(8'h19), .EXP_VECTORS(3)) dut_a (
    .CLK(CLK), .RESET(RESET), .OUT(OUT), .RUNNING(RUNNING), .FINISH(FINISH), .BIST_END(BIST_END),
    .CUT_DATA(CUT_DATA), .SIGNATURE(a_sig), .VEC_COUNT(a_cnt), .BUSY(a_busy),
    .RESULT_VALID(a_rv), .PASS(a_pass), .FAIL(a_fail));

  bist_misr_checker #(.W(8), .POLY(8'h1D), .INIT(8'h00), .GOLDEN(GOLD_B), .EXP_VECTORS(144)) dut_b (
    .CLK(CLK), .RESET(RESET), .OUT(OUT), .RUNNING(RUNNING), .FINISH(FINISH), .BIST_END(BIST_END),
    .CUT_DATA(CUT_DATA), .SIGNATURE(b_sig), .VEC_COUNT(b_cnt), .BUSY(b_busy),
    .RESULT_VALID(b_rv), .PASS(b_pass), .FAIL(b_fail));

  typedef struct {
    logic       sel;   // 0: dut_a, 1: dut_b
    logic [7:0] sig;
    logic [9:0] cnt;
    logic       busy, rv, pass, fail;
  } exp_t;

  typedef struct {
    logic       rst, out, fin, bend;
    logic [7:0] dat;
    logic [7:0] sig;
    logic [9:0] cnt;
    logic       busy, rv, pass, fail;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[25];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t       e;
    logic [7:0] s;
    logic [9:0] c;
    logic       b, v, p, f;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s.scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = sb_q.pop_front();
    if (e.sel) begin
      s = b_sig; c = b_cnt; b = b_busy; v = b_rv; p = b_pass; f = b_fail;
    end else begin
      s = a_sig; c = a_cnt; b = a_busy; v = a_rv; p = a_pass; f = a_fail;
    end
    cmp({tag, ".sig"},  32'(s), 32'(e.sig));
    cmp({tag, ".cnt"},  32'(c), 32'(e.cnt));
    cmp({tag, ".busy"}, 32'(b), 32'(e.busy));
    cmp({tag, ".rv"},   32'(v), 32'(e.rv));
    cmp({tag, ".pass"}, 32'(p), 32'(e.pass));
    cmp({tag, ".fail"}, 32'(f), 32'(e.fail));
    cmp({tag, ".excl"}, 32'(p & f), 32'(0));
  endtask

  // Drive one cycle of stimulus, queue what must be visible after the next edge, then check it.
  task automatic apply(input string tag, input logic sel, input logic rst, input logic out,
                       input logic fin, input logic bend, input logic [7:0] dat,
                       input logic [7:0] sig, input logic [9:0] cnt,
                       input logic busy, input logic rv, input logic pass, input logic fail);
    exp_t e;
    RESET = rst; OUT = out; FINISH = fin; BIST_END = bend; CUT_DATA = dat;
    e.sel = sel; e.sig = sig; e.cnt = cnt; e.busy = busy; e.rv = rv; e.pass = pass; e.fail = fail;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    check_out(tag);
  endtask

  // A 9 x 16 controller run with an idle gap after each group, FINISH, a DONE hold, then BIST_END drop.
  task automatic full_run(input string tag);
    logic [7:0] s;
    logic [9:0] c;
    s = 8'h00;
    c = 10'd0;
    RUNNING = H;
    for (int n = 0; n < 9; n++) begin
      for (int m = 0; m < 16; m++) begin
        s = misr(s, word(n * 16 + m));
        c = c + 10'd1;
        apply($sformatf("%s.w%0d", tag, n * 16 + m), H, L, H, L, H, word(n * 16 + m), s, c, H, L, L, L);
      end
      apply($sformatf("%s.gap%0d", tag, n), H, L, L, L, H, 8'h00, s, c, H, L, L, L);
    end
    RUNNING = L;
    apply({tag, ".cmp"},  H, L, L, H, H, 8'h00, s, c, L, L, L, L);
    apply({tag, ".res"},  H, L, L, L, H, 8'h00, s, c, L, H, H, L);
    cmp({tag, ".a_fail"}, 32'(a_fail), 32'(1));
    cmp({tag, ".a_cnt"},  32'(a_cnt),  32'(144));
    apply({tag, ".hold"}, H, L, H, H, H, 8'h5A, s, c, L, H, H, L);
    apply({tag, ".clr"},  H, L, L, L, L, 8'h00, 8'h00, 10'd0, L, L, L, L);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s;
    logic [9:0] c;

    RESET = H; OUT = L; RUNNING = L; FINISH = L; BIST_END = L; CUT_DATA = 8'h00;

    //          rst out fin bend dat     sig    cnt    busy rv pass fail
    // reset held with OUT high and all-ones data
    tbl[0]  = '{H, H, L, L, 8'hFF, 8'h00, 10'd0, L, L, L, L};
    tbl[1]  = '{H, H, L, L, 8'hFF, 8'h00, 10'd0, L, L, L, L};
    // short passing run: 01, 80, 00 -> 01, 82, 19
    tbl[2]  = '{L, H, L, H, 8'h01, 8'h01, 10'd1, H, L, L, L};
    tbl[3]  = '{L, H, L, H, 8'h80, 8'h82, 10'd2, H, L, L, L};
    tbl[4]  = '{L, H, L, H, 8'h00, 8'h19, 10'd3, H, L, L, L};
    tbl[5]  = '{L, L, L, H, 8'h77, 8'h19, 10'd3, H, L, L, L};
    tbl[6]  = '{L, L, H, H, 8'h00, 8'h19, 10'd3, L, L, L, L};
    tbl[7]  = '{L, L, L, H, 8'h00, 8'h19, 10'd3, L, H, H, L};
    tbl[8]  = '{L, H, H, H, 8'hAA, 8'h19, 10'd3, L, H, H, L};
    tbl[9]  = '{L, L, L, L, 8'h00, 8'h00, 10'd0, L, L, L, L};
    // extra word 00 -> signature 32, count 4 -> FAIL
    tbl[10] = '{L, H, L, H, 8'h01, 8'h01, 10'd1, H, L, L, L};
    tbl[11] = '{L, H, L, H, 8'h80, 8'h82, 10'd2, H, L, L, L};
    tbl[12] = '{L, H, L, H, 8'h00, 8'h19, 10'd3, H, L, L, L};
    tbl[13] = '{L, H, L, H, 8'h00, 8'h32, 10'd4, H, L, L, L};
    tbl[14] = '{L, L, H, H, 8'h00, 8'h32, 10'd4, L, L, L, L};
    tbl[15] = '{L, L, L, H, 8'h00, 8'h32, 10'd4, L, H, L, H};
    tbl[16] = '{L, L, L, L, 8'h00, 8'h00, 10'd0, L, L, L, L};
    // last word coincides with FINISH: compacted, then graded
    tbl[17] = '{L, H, L, H, 8'h01, 8'h01, 10'd1, H, L, L, L};
    tbl[18] = '{L, H, L, H, 8'h80, 8'h82, 10'd2, H, L, L, L};
    tbl[19] = '{L, H, H, H, 8'h00, 8'h19, 10'd3, L, L, L, L};
    tbl[20] = '{L, L, L, H, 8'h00, 8'h19, 10'd3, L, H, H, L};
    tbl[21] = '{L, L, L, L, 8'h00, 8'h00, 10'd0, L, L, L, L};
    // FINISH straight from IDLE with no words
    tbl[22] = '{L, L, H, H, 8'h00, 8'h00, 10'd0, L, L, L, L};
    tbl[23] = '{L, L, L, H, 8'h00, 8'h00, 10'd0, L, H, L, H};
    tbl[24] = '{L, L, L, L, 8'h00, 8'h00, 10'd0, L, L, L, L};

    for (int i = 0; i < 25; i++) begin
      apply($sformatf("tbl%0d", i), L, tbl[i].rst, tbl[i].out, tbl[i].fin, tbl[i].bend, tbl[i].dat,
            tbl[i].sig, tbl[i].cnt, tbl[i].busy, tbl[i].rv, tbl[i].pass, tbl[i].fail);
    end

    // Two back-to-back controller runs must both grade PASS on the 144-word instance.
    full_run("run1");
    full_run("run2");

    // Abort after 50 words: reset returns to INIT and no verdict ever appears.
    s = 8'h00;
    c = 10'd0;
    RUNNING = H;
    for (int i = 0; i < 50; i++) begin
      s = misr(s, word(i));
      c = c + 10'd1;
      apply($sformatf("abort.w%0d", i), H, L, H, L, H, word(i), s, c, H, L, L, L);
    end
    RUNNING = L;
    apply("abort.rst", H, H, H, L, H, 8'hFF, 8'h00, 10'd0, L, L, L, L);
    for (int i = 0; i < 3; i++) begin
      apply($sformatf("abort.idle%0d", i), H, L, L, L, H, 8'h00, 8'h00, 10'd0, L, L, L, L);
    end
    cmp("abort.a_rv", 32'(a_rv), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
